// File: rtl/host_instr_sender.sv
// Host-side instruction streamer: stages a program in a FIFO, then feeds it to the accelerator on start.
// Optional stall watchdog enabled by defining SENDER_TIMEOUT_EN (adds the timeout port).
module host_instr_sender #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 64,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               load_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sent_count,
  output logic [INSTR_W-1:0] accelerator_input,
  output logic               instr_valid,
  input  logic               buffer_full
`ifdef SENDER_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("host_instr_sender: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic [1:0]         r_state;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic               r_done;
  logic [CNT_W-1:0]   r_sent;

  logic               w_load;
  logic               w_xfer;
  logic [AW:0]        w_cnt_next;
  logic [AW-1:0]      w_rptr_nxt;
  logic [INSTR_W-1:0] w_head;

`ifdef SENDER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);
  logic [SW-1:0] r_stall;
  logic          r_timeout;
  assign timeout = r_timeout;
`endif

  assign load_ready        = (r_state == IDLE) && (r_count != FULL_CNT);
  assign busy              = (r_state == SEND);
  assign done              = r_done;
  assign sent_count        = r_sent;
  assign accelerator_input = r_instr;
  assign instr_valid       = r_valid;

  assign w_load     = load_valid && load_ready;
  assign w_xfer     = r_valid && !buffer_full;
  assign w_cnt_next = r_count + {{AW{1'b0}}, w_load};
  assign w_rptr_nxt = r_rptr + 1'b1;
  // A load landing in the same cycle as start into an empty FIFO becomes the head directly.
  assign w_head     = (r_count == '0) ? load_instr : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_load) r_mem[r_wptr] <= load_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_done  <= 1'b0;
      r_sent  <= '0;
`ifdef SENDER_TIMEOUT_EN
      r_stall   <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_load) r_wptr <= r_wptr + 1'b1;
      case (r_state)
        IDLE: begin
          r_count <= w_cnt_next;
          if (start) begin
            r_sent <= '0;
`ifdef SENDER_TIMEOUT_EN
            r_stall   <= '0;
            r_timeout <= 1'b0;
`endif
            if (w_cnt_next != '0) begin
              r_state <= SEND;
              r_valid <= 1'b1;
              r_instr <= w_head;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (w_xfer) begin
            r_sent  <= r_sent + 1'b1;
            r_rptr  <= w_rptr_nxt;
            r_count <= r_count - ONE_CNT;
`ifdef SENDER_TIMEOUT_EN
            r_stall <= '0;
`endif
            if (r_count > ONE_CNT) begin
              r_instr <= r_mem[w_rptr_nxt];
            end else begin
              r_valid <= 1'b0;
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
`ifdef SENDER_TIMEOUT_EN
          else if (buffer_full) begin
            // Give up on the stalled program: drop everything staged and finish normally.
            if (r_stall == STALL_LIM) begin
              r_timeout <= 1'b1;
              r_count   <= '0;
              r_rptr    <= r_wptr;
              r_valid   <= 1'b0;
              r_state   <= FIN;
              r_done    <= 1'b1;
            end else begin
              r_stall <= r_stall + 1'b1;
            end
          end
`endif
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_instr_sender.sv
// Directed testbench for host_instr_sender (define SENDER_TIMEOUT_EN to also exercise the watchdog).
module tb_host_instr_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [63:0] load_instr;
  logic        load_ready;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  sent_count;
  logic [63:0] accelerator_input;
  logic        instr_valid;
  logic        buffer_full;
`ifdef SENDER_TIMEOUT_EN
  logic        timeout;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  host_instr_sender #(
    .DEPTH(16), .INSTR_W(64), .CNT_W(8), .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_instr(load_instr),
    .load_ready(load_ready),
    .start(start),
    .busy(busy),
    .done(done),
    .sent_count(sent_count),
    .accelerator_input(accelerator_input),
    .instr_valid(instr_valid),
    .buffer_full(buffer_full)
`ifdef SENDER_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [63:0] v);
    load_valid = 1'b1;
    load_instr = v;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Loads n entries base+0..base+n-1, streams them without backpressure and checks order, done and count.
  task automatic load_and_send(input int n, input logic [63:0] base, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_ready"}, 64'(load_ready), 64'd1);
      load_one(base + 64'(i));
    end
    pulse_start();
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 64'(instr_valid), 64'd1);
      check({tag, "_data"}, accelerator_input, base + 64'(i));
      tick();
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_valid_off"}, 64'(instr_valid), 64'd0);
    check({tag, "_count"}, 64'(sent_count), 64'(n));
    tick();
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset       = 1'b0;
    load_valid  = 1'b1;
    load_instr  = 64'hBAD;
    start       = 1'b0;
    buffer_full = 1'b0;

    // 1: reset values with load_valid held, then a 4-instruction program
    repeat (2) tick();
    check("rst_ready", 64'(load_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_data", accelerator_input, 64'd0);
    check("rst_count", 64'(sent_count), 64'd0);
`ifdef SENDER_TIMEOUT_EN
    check("rst_timeout", 64'(timeout), 64'd0);
`endif
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    load_and_send(4, 64'h1, "t1");

    // 2: backpressure on the second instruction
    load_one(64'h21);
    load_one(64'h22);
    load_one(64'h23);
    pulse_start();
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_first", accelerator_input, 64'h21);
    tick();
    buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_data", accelerator_input, 64'h22);
      check("t2_hold_valid", 64'(instr_valid), 64'd1);
      check("t2_hold_count", 64'(sent_count), 64'd1);
      check("t2_hold_done", 64'(done), 64'd0);
    end
    buffer_full = 1'b0;
    tick();
    check("t2_third", accelerator_input, 64'h23);
    check("t2_count2", 64'(sent_count), 64'd2);
    tick();
    check("t2_done", 64'(done), 64'd1);
    check("t2_count", 64'(sent_count), 64'd3);
    check("t2_valid_off", 64'(instr_valid), 64'd0);
    tick();

    // 3: fill to full, reject a 17th offer, send; then reload 16 across the pointer wrap
    for (int i = 0; i < 16; i++) load_one(64'h100 + 64'(i));
    check("t3_full_ready", 64'(load_ready), 64'd0);
    load_one(64'hDEAD);
    check("t3_full_ready2", 64'(load_ready), 64'd0);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      check("t3_data", accelerator_input, 64'h100 + 64'(i));
      tick();
    end
    check("t3_done", 64'(done), 64'd1);
    check("t3_count", 64'(sent_count), 64'd16);
    tick();
    load_and_send(16, 64'h200, "t3b");

    // 4: start with an empty FIFO
    pulse_start();
    check("t4_done", 64'(done), 64'd1);
    check("t4_valid", 64'(instr_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_count", 64'(sent_count), 64'd0);
    tick();
    check("t4_done_1cyc", 64'(done), 64'd0);

    // 5: reset mid-stream after two transfers
    for (int i = 0; i < 8; i++) load_one(64'h300 + 64'(i));
    pulse_start();
    tick();
    tick();
    check("t5_count2", 64'(sent_count), 64'd2);
    check("t5_data", accelerator_input, 64'h302);
    reset = 1'b0;
    #1;
    check("t5_valid", 64'(instr_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_count", 64'(sent_count), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t5_ready", 64'(load_ready), 64'd1);
    pulse_start();
    check("t5_empty_done", 64'(done), 64'd1);
    check("t5_empty_valid", 64'(instr_valid), 64'd0);
    tick();

`ifdef SENDER_TIMEOUT_EN
    // 6: watchdog fires after 10 stalled cycles following one transfer
    begin
      int cycles;
      cycles = 0;
      load_one(64'h401);
      load_one(64'h402);
      load_one(64'h403);
      pulse_start();
      tick();
      check("t6_count1", 64'(sent_count), 64'd1);
      buffer_full = 1'b1;
      while (!done && cycles < 20) begin
        tick();
        cycles++;
      end
      check("t6_cycles", 64'(cycles), 64'd10);
      check("t6_timeout", 64'(timeout), 64'd1);
      check("t6_count", 64'(sent_count), 64'd1);
      check("t6_valid", 64'(instr_valid), 64'd0);
      buffer_full = 1'b0;
      tick();
      check("t6_sticky", 64'(timeout), 64'd1);
      check("t6_ready", 64'(load_ready), 64'd1);
      pulse_start();
      check("t6_flushed_done", 64'(done), 64'd1);
      check("t6_cleared", 64'(timeout), 64'd0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
